// File: rtl/grid_walk_fsm.sv
// grid_walk_fsm
//   Moore walker on a COLS x ROWS torus. A 2-bit command, qualified by
//   in_valid, steps the registered (col, row) position. y flags the
//   configured target position once the machine has been armed by its
//   first clock edge out of reset. With default parameters it behaves as
//   the lab's 6-state single-input sequence detector (cmd 00 / 01).
//
//   Optional feature: define GRID_HIT_CNT_EN to build a saturating
//   counter of target entries and expose it on hit_count.
//
// Ports
//   clk       in   clock, rising edge
//   rst       in   synchronous active-high reset
//   in_valid  in   command qualifier (cmd ignored when low)
//   cmd       in   00 row+1, 01 col+1, 10 col-1, 11 hold
//   col       out  current column  [CW-1:0]
//   row       out  current row     [RW-1:0]
//   y         out  armed & (position == target)
//   wrap      out  one-cycle pulse after a column wrap
//   hit_count out  saturating target-entry count (GRID_HIT_CNT_EN only)
module grid_walk_fsm #(
  parameter int COLS       = 3,
  parameter int ROWS       = 2,
  parameter int RESET_COL  = 2,
  parameter int RESET_ROW  = 1,
  parameter int TARGET_COL = 2,
  parameter int TARGET_ROW = 1,
  parameter int CNT_W      = 8,
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1,
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [1:0]    cmd,
  output logic [CW-1:0] col,
  output logic [RW-1:0] row,
  output logic          y,
  output logic          wrap
`ifdef GRID_HIT_CNT_EN
  ,
  output logic [CNT_W-1:0] hit_count
`endif
);

  typedef enum logic [1:0] {
    CMD_ROW_INC = 2'b00,
    CMD_COL_INC = 2'b01,
    CMD_COL_DEC = 2'b10,
    CMD_HOLD    = 2'b11
  } cmd_e;

  localparam logic [CW-1:0] COL_MAX = CW'(COLS - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(ROWS - 1);
  localparam logic [CW-1:0] COL_ONE = CW'(1);
  localparam logic [RW-1:0] ROW_ONE = RW'(1);
  localparam logic [CW-1:0] COL_RST = CW'(RESET_COL);
  localparam logic [RW-1:0] ROW_RST = RW'(RESET_ROW);
  localparam logic [CW-1:0] COL_TGT = CW'(TARGET_COL);
  localparam logic [RW-1:0] ROW_TGT = RW'(TARGET_ROW);
  // A target outside the grid can never match; without this guard the
  // width truncation above could alias it onto a real position.
  localparam bit TGT_IN_GRID = (TARGET_COL >= 0) && (TARGET_COL < COLS) &&
                               (TARGET_ROW >= 0) && (TARGET_ROW < ROWS);

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic          wrap_q, wrap_d;
  logic          armed_q;
  logic          match_cur, match_nxt;

  // Next-state decode. Wrap points are compared explicitly so that
  // non-power-of-two sizes wrap at COLS-1 / ROWS-1, not at 2^W-1.
  always_comb begin
    col_d  = col_q;
    row_d  = row_q;
    wrap_d = 1'b0;
    if (in_valid) begin
      case (cmd_e'(cmd))
        CMD_ROW_INC: row_d = (row_q == ROW_MAX) ? '0 : row_q + ROW_ONE;
        CMD_COL_INC: begin
          if (col_q == COL_MAX) begin
            col_d  = '0;
            wrap_d = 1'b1;
          end else begin
            col_d  = col_q + COL_ONE;
          end
        end
        CMD_COL_DEC: begin
          if (col_q == '0) begin
            col_d  = COL_MAX;
            wrap_d = 1'b1;
          end else begin
            col_d  = col_q - COL_ONE;
          end
        end
        CMD_HOLD: ;
        default: ;
      endcase
    end
  end

  assign match_cur = TGT_IN_GRID && (col_q == COL_TGT) && (row_q == ROW_TGT);
  assign match_nxt = TGT_IN_GRID && (col_d == COL_TGT) && (row_d == ROW_TGT);

  // State register: rst wins over any command sampled on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_q   <= COL_RST;
      row_q   <= ROW_RST;
      wrap_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      wrap_q  <= wrap_d;
      armed_q <= 1'b1;
    end
  end

  assign col  = col_q;
  assign row  = row_q;
  assign wrap = wrap_q;
  // Derived only from registers: the armed bit masks the first cycle after
  // reset even when the reset position is the target.
  assign y    = armed_q & match_cur;

`ifdef GRID_HIT_CNT_EN
  localparam logic [CNT_W-1:0] HIT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] HIT_MAX = '1;

  logic [CNT_W-1:0] hit_q;

  // Every non-reset edge is either armed or the arming edge itself, so an
  // entry (next on target, current off target) always counts here.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_q <= '0;
    end else if (match_nxt && !match_cur && (hit_q != HIT_MAX)) begin
      hit_q <= hit_q + HIT_ONE;
    end
  end

  assign hit_count = hit_q;
`endif

endmodule

// File: doc/grid_walk_fsm.md
# grid_walk_fsm

Parametrised Moore sequence FSM. Its state is a (column, row) position on a COLS x ROWS torus, stepped by a 2-bit command under a valid qualifier. A masked match output `y` flags a configured target position. With default parameters it reproduces the lab's 6-state single-input sequence detector (cmd 2'b00 = old X=0, cmd 2'b01 = old X=1), and adds hold, reverse stepping, a wrap indicator and an optional hit counter. It sits between the stimulus/input-sync stage and the lab display logic.

## Interface
- COLS, default 3: column count, ≥2.
- ROWS, default 2: row count, ≥2.
- RESET_COL, default 2: column loaded on reset, < COLS.
- RESET_ROW, default 1: row loaded on reset, < ROWS.
- TARGET_COL, default 2: column at which `y` asserts.
- TARGET_ROW, default 1: row at which `y` asserts.
- CNT_W, default 8: hit counter width (used only with the macro).
- clk, input, 1: clock, rising edge.
- rst, input, 1: reset, synchronous, active-high.
- in_valid, input, 1: command qualifier; cmd is ignored when low.
- cmd, input, 2: 00 row+1, 01 col+1, 10 col-1, 11 hold.
- col, output, CW = max(1, $clog2(COLS)): current column.
- row, output, RW = max(1, $clog2(ROWS)): current row.
- y, output, 1: target match, masked until armed.
- wrap, output, 1: one-cycle column-wrap pulse.
- hit_count, output, CNT_W: saturating target-entry count (`GRID_HIT_CNT_EN` only).

## Operation
- State is registered {col, row} plus a single `armed` bit.
- Reset:
  - col = RESET_COL, row = RESET_ROW.
  - armed = 0, wrap = 0, hit_count = 0.
  - y = 0.
- `armed` goes to 1 on the first clock edge with rst low and stays 1 until the next reset. It is independent of in_valid.
- Next state when in_valid = 1:
  - 00: row = (row+1) mod ROWS; col unchanged.
  - 01: col = (col+1) mod COLS; row unchanged.
  - 10: col = (col == 0) ? COLS-1 : col-1; row unchanged.
  - 11: hold.
- When in_valid = 0: hold regardless of cmd.
- y = armed & (col == TARGET_COL) & (row == TARGET_ROW). It is purely a function of registers (Moore), with no input-to-output combinational path.
- wrap is registered. It is 1 in the cycle after an edge that took col from COLS-1 to 0 via cmd 01, or from 0 to COLS-1 via cmd 10. Otherwise it is 0.
- Row wrap does not pulse `wrap`.
- Arithmetic is compared at full CW/RW width, with no reliance on natural overflow. Non-power-of-two COLS/ROWS must wrap exactly at COLS-1/ROWS-1.
- rst has priority over in_valid in the same cycle; the command is discarded.

## Timing
- Command-to-state latency is 1 clock: col/row update on the edge that samples in_valid = 1.
- y and wrap reflect the new state in the same cycle col/row do.
- After rst deasserts: y stays 0 for the first cycle even when reset state equals target (default parameters). From the second cycle y follows state.
- Back-to-back valid commands are accepted every cycle; there is no backpressure.
- Reset mid-walk: the state returns to reset values on that edge, armed clears, and y drops the same cycle.

## Configuration
- `GRID_HIT_CNT_EN` defined:
  - hit_count increments by 1 on each edge where the next state equals the target and the current state does not. Entries count; dwelling does not.
  - Entry is counted only while armed, or when arming occurs on the same edge.
  - hit_count saturates at 2^CNT_W-1 and clears on reset.
- Not defined: the hit_count port is absent and no counter logic is built. All other behaviour is identical.

## Test plan
- Reset with defaults, rst high 2 cycles then low, in_valid = 0 → col = 2, row = 1, y = 0 in the first cycle after release, y = 1 from the second cycle.
- Defaults from reset, valid cmd sequence 01, 01, 01 → col steps 2→0→1→2; wrap = 1 only in the cycle col = 0; y returns to 1 on the third step.
- Defaults, cmd 00 twice then 10 once → row 1→0→1, then col 2→1; y = 1 after the second step, 0 after the third.
- COLS = 5, ROWS = 3, RESET = (0,0), cmd 10 once → col = 4 and wrap = 1; then 01 → col = 0 and wrap = 1; cmd 00 ×3 → row 0→1→2→0.
- in_valid = 0 with cmd 01 for 4 cycles, then cmd 11 valid → state unchanged throughout; rst asserted together with valid cmd 01 → state = reset values and y = 0.
- `GRID_HIT_CNT_EN`, CNT_W = 2, defaults: leave and re-enter the target 5 times → hit_count 1, 2, 3, 3, 3; dwelling 4 cycles on target adds nothing.
